rs_latch_seq_ctrl: RTL and testbench

//   Sequencer and self-checker for the active-low NAND R-S latch on the EGO1 board.

---
 rtl/rs_latch_seq_ctrl_if.sv | 13 +
 rtl/rs_latch_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rs_latch_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rs_latch_seq_ctrl_if.sv
// Latch-side bus between the sequencer and the NAND R-S latch.
//   rs_rn, rs_sn : active-low /R and /S drive toward the latch
//   q_in, qn_in  : latch Q and /Q returned to the sequencer (asynchronous)
// master = sequencer side, slave = latch side.
interface rs_latch_seq_ctrl_if;
  logic rs_rn;
  logic rs_sn;
  logic q_in;
  logic qn_in;

  modport master (output rs_rn, rs_sn, input  q_in, qn_in);
  modport slave  (input  rs_rn, rs_sn, output q_in, qn_in);
endinterface

// File: rtl/rs_latch_seq_ctrl.sv
// Sequencer and self-checker for an active-low NAND R-S latch.
// Walks /R,/S through a fixed 6-step table, samples Q and /Q after a settle
// window, counts mismatches and reports status on the LEDs.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   sw_pin   [0] run, [1] mode (0 auto, 1 manual), [2] loop, [7:3] unused
//   btn_pin  raw step button (manual mode)
//   lat      latch bus: rs_rn/rs_sn drive, q_in/qn_in sense
//   led_pin  [2:0] idx, [3] busy, [4] done, [5] pass, [6] err sticky,
//            [7] last-check mismatch, [15:8] error count
module rs_latch_seq_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SETTLE_CYC = 4,
  parameter int DEB_CYC    = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 sw_pin,
  input  logic                       btn_pin,
  rs_latch_seq_ctrl_if.master        lat,
  output logic [15:0]                led_pin
);

  localparam int CNT_MAX = (TICK_DIV > SETTLE_CYC) ? TICK_DIV : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_WAIT, S_DONE} state_t;

  // {/R, /S, expected Q}; no entry drives /R=/S=0
  function automatic logic [2:0] step_tab(input logic [2:0] i);
    case (i)
      3'd0:    step_tab = 3'b010;
      3'd1:    step_tab = 3'b110;
      3'd2:    step_tab = 3'b101;
      3'd3:    step_tab = 3'b111;
      3'd4:    step_tab = 3'b010;
      default: step_tab = 3'b110;
    endcase
  endfunction

  logic unused_sw;
  assign unused_sw = ^sw_pin[7:3];

  // ---- input synchronizers ----
  logic [2:0] sw_m_q, sw_s_q;
  logic       q_m_q, q_s_q, qn_m_q, qn_s_q, btn_m_q, btn_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m_q <= '0; sw_s_q <= '0;
      q_m_q <= 1'b0; q_s_q <= 1'b0; qn_m_q <= 1'b0; qn_s_q <= 1'b0;
      btn_m_q <= 1'b0; btn_s_q <= 1'b0;
    end else begin
      sw_m_q <= sw_pin[2:0]; sw_s_q <= sw_m_q;
      q_m_q <= lat.q_in;     q_s_q  <= q_m_q;
      qn_m_q <= lat.qn_in;   qn_s_q <= qn_m_q;
      btn_m_q <= btn_pin;    btn_s_q <= btn_m_q;
    end
  end

  // ---- debouncer: accept a new level only after DEB_CYC consecutive cycles ----
  logic [DW-1:0] dcnt_q;
  logic          deb_q, deb_prev_q, step_pls;

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q <= '0; deb_q <= 1'b0; deb_prev_q <= 1'b0;
    end else begin
      deb_prev_q <= deb_q;
      if (btn_s_q == deb_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DW'(DEB_CYC - 1)) begin
        deb_q  <= btn_s_q;
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  assign step_pls = deb_q & ~deb_prev_q;

  // ---- sequencer FSM ----
  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    err_q, err_d;
  logic          sticky_q, sticky_d, mis_q, mis_d, done_q, done_d, pass_q, pass_d;
  logic          rn_q, rn_d, sn_q, sn_d, mode_q, mode_d, run_prev_q;
  logic          run_rise, busy, mismatch, leave;
  logic [2:0]    tab;

  assign tab      = step_tab(idx_q);
  assign run_rise = sw_s_q[0] & ~run_prev_q;
  assign busy     = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                    (state_q == S_CHECK) || (state_q == S_WAIT);
  assign mismatch = (q_s_q != tab[0]) | (qn_s_q != ~q_s_q);
  assign leave    = mode_q ? step_pls : (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; idx_q <= '0; cnt_q <= '0; err_q <= '0;
      sticky_q <= 1'b0; mis_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0;
      rn_q <= 1'b1; sn_q <= 1'b1; mode_q <= 1'b0; run_prev_q <= 1'b0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; cnt_q <= cnt_d; err_q <= err_d;
      sticky_q <= sticky_d; mis_q <= mis_d; done_q <= done_d; pass_q <= pass_d;
      rn_q <= rn_d; sn_q <= sn_d; mode_q <= mode_d; run_prev_q <= sw_s_q[0];
    end
  end

  always_comb begin
    state_d = state_q; idx_d = idx_q; cnt_d = cnt_q; err_d = err_q;
    sticky_d = sticky_q; mis_d = mis_q; done_d = done_q; pass_d = pass_q;
    rn_d = rn_q; sn_d = sn_q; mode_d = mode_q;
    case (state_q)
      S_IDLE: if (run_rise) begin
        err_d = '0; sticky_d = 1'b0; mis_d = 1'b0; done_d = 1'b0; pass_d = 1'b0;
        idx_d = '0; state_d = S_APPLY;
      end
      S_APPLY: begin
        {rn_d, sn_d} = tab[2:1];
        cnt_d = '0; state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          cnt_d = '0; state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        mis_d = mismatch;
        if (mismatch) begin
          sticky_d = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        // mode is latched here so a mid-run switch lands on the next WAIT
        mode_d = sw_s_q[1]; cnt_d = '0; state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!leave) begin
          cnt_d = cnt_q + 1'b1;
        end else if (idx_q != 3'd5) begin
          idx_d = idx_q + 3'd1; state_d = S_APPLY;
        end else if (sw_s_q[2]) begin
          idx_d = '0; state_d = S_APPLY;
        end else begin
          done_d = 1'b1; pass_d = (err_q == 8'd0); state_d = S_DONE;
        end
      end
      S_DONE: if (!sw_s_q[0]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort keeps idx/status for inspection
    if (busy && !sw_s_q[0]) begin
      state_d = S_IDLE; idx_d = idx_q; done_d = done_q; pass_d = pass_q;
    end
    if (state_d == S_IDLE || state_d == S_DONE) begin
      rn_d = 1'b1; sn_d = 1'b1;
    end
  end

  assign lat.rs_rn = rn_q;
  assign lat.rs_sn = sn_q;
  assign led_pin   = {err_q, mis_q, sticky_q, pass_q, done_q, busy, idx_q};

endmodule

// File: tb/tb_rs_latch_seq_ctrl.sv
module tb_rs_latch_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw  = 8'h00;
  logic        btn = 1'b0;
  logic [15:0] led;
  logic        fault = 1'b0;
  logic        lq = 1'b0, lqn = 1'b1;
  logic        log_en = 1'b0;
  logic [1:0]  drv_prev = 2'b11;
  logic [1:0]  drv_log[$];
  logic [1:0]  exp_drv[6];
  int          checks = 0, errors = 0;
  int          n;

  always #5 clk = ~clk;

  rs_latch_seq_ctrl_if bus();

  rs_latch_seq_ctrl #(.TICK_DIV(10), .SETTLE_CYC(4), .DEB_CYC(3)) dut (
    .clk(clk), .rst(rst), .sw_pin(sw), .btn_pin(btn), .lat(bus), .led_pin(led)
  );

  // behavioural NAND latch, 1-cycle gate delay
  assign bus.q_in  = fault ? 1'b1 : lq;
  assign bus.qn_in = lqn;
  always @(posedge clk) begin
    lq  <= ~(bus.rs_sn & lqn);
    lqn <= ~(bus.rs_rn & lq);
  end

  // forbidden-drive invariant and drive-change log
  always @(negedge clk) begin
    checks++;
    assert ((bus.rs_rn | bus.rs_sn) === 1'b1) else begin
      errors++;
      $error("FAIL invariant observed rn=%b sn=%b expected rn|sn=1", bus.rs_rn, bus.rs_sn);
    end
    if (log_en && {bus.rs_rn, bus.rs_sn} != drv_prev) drv_log.push_back({bus.rs_rn, bus.rs_sn});
    drv_prev <= {bus.rs_rn, bus.rs_sn};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bit(input int b, input logic v, input int lim, input string tag);
    int k = 0;
    while (led[b] !== v && k < lim) begin @(negedge clk); k++; end
    chk(tag, 16'(k < lim), 16'd1);
  endtask

  task automatic wait_idx(input logic [2:0] v, input int lim, input string tag);
    int k = 0;
    while (led[2:0] !== v && k < lim) begin @(negedge clk); k++; end
    chk(tag, 16'(k < lim), 16'd1);
  endtask

  initial begin
    exp_drv = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    // reset
    repeat (2) @(negedge clk);
    chk("rst drive", 16'({bus.rs_rn, bus.rs_sn}), 16'b11);
    chk("rst led", led, 16'h0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // auto run, healthy latch
    log_en = 1'b1; sw = 8'h01;
    wait_bit(3, 1'b1, 50, "auto busy timeout");
    n = 0;
    while (led[4] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("auto cycles", 16'(n), 16'd96);
    log_en = 1'b0;
    chk("auto drive count", 16'(drv_log.size()), 16'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("auto drive %0d", i), 16'(drv_log[i]), 16'(exp_drv[i]));
    chk("auto done", 16'(led[4]), 16'd1);
    chk("auto pass", 16'(led[5]), 16'd1);
    chk("auto sticky", 16'(led[6]), 16'd0);
    chk("auto lastmis", 16'(led[7]), 16'd0);
    chk("auto errcnt", 16'(led[15:8]), 16'd0);
    chk("auto idx", 16'(led[2:0]), 16'd5);
    chk("auto busy end", 16'(led[3]), 16'd0);
    sw = 8'h00;
    repeat (5) @(negedge clk);
    chk("idle status kept", 16'(led[4]), 16'd1);
    chk("idle drive", 16'({bus.rs_rn, bus.rs_sn}), 16'b11);

    // Q stuck high
    fault = 1'b1; sw = 8'h01;
    wait_bit(3, 1'b1, 50, "fault busy timeout");
    wait_bit(4, 1'b1, 300, "fault done timeout");
    chk("fault errcnt", 16'(led[15:8]), 16'd4);
    chk("fault sticky", 16'(led[6]), 16'd1);
    chk("fault pass", 16'(led[5]), 16'd0);
    chk("fault lastmis", 16'(led[7]), 16'd1);
    sw = 8'h00; fault = 1'b0;
    repeat (5) @(negedge clk);

    // manual stepping
    sw = 8'h03;
    wait_bit(3, 1'b1, 50, "manual busy timeout");
    repeat (40) @(negedge clk);
    chk("manual idx hold", 16'(led[2:0]), 16'd0);
    chk("manual busy", 16'(led[3]), 16'd1);
    for (int k = 0; k < 3; k++) begin
      btn = 1'b1; repeat (5) @(negedge clk);
      btn = 1'b0; repeat (15) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("manual idx 3", 16'(led[2:0]), 16'd3);
    btn = 1'b1; @(negedge clk); btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("manual glitch", 16'(led[2:0]), 16'd3);
    sw = 8'h00;
    repeat (5) @(negedge clk);
    chk("manual abort busy", 16'(led[3]), 16'd0);
    chk("manual abort idx", 16'(led[2:0]), 16'd3);

    // loop with wrap, then abort at idx 2
    sw = 8'h05;
    wait_bit(3, 1'b1, 50, "loop busy timeout");
    wait_idx(3'd5, 200, "loop idx5 timeout");
    wait_idx(3'd0, 100, "loop wrap timeout");
    chk("loop done", 16'(led[4]), 16'd0);
    chk("loop busy", 16'(led[3]), 16'd1);
    wait_idx(3'd2, 100, "loop idx2 timeout");
    sw = 8'h00;
    repeat (4) @(negedge clk);
    chk("abort busy", 16'(led[3]), 16'd0);
    chk("abort idx", 16'(led[2:0]), 16'd2);
    chk("abort drive", 16'({bus.rs_rn, bus.rs_sn}), 16'b11);
    chk("abort done", 16'(led[4]), 16'd0);

    // reset during SETTLE
    repeat (3) @(negedge clk);
    sw = 8'h01;
    wait_bit(3, 1'b1, 50, "rst busy timeout");
    repeat (2) @(negedge clk);
    chk("settle drive", 16'({bus.rs_rn, bus.rs_sn}), 16'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst led", led, 16'h0000);
    chk("midrst drive", 16'({bus.rs_rn, bus.rs_sn}), 16'b11);
    rst = 1'b0; sw = 8'h00;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
